// File: rtl/crc_pkg.sv
// Shared CRC helpers: bit reversal and a width-generic serial CRC step.
// Widths are passed as arguments so one function set serves every engine configuration.
package crc_pkg;

  localparam int MAX_CRC_W  = 32;
  localparam int MAX_DATA_W = 64;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [MAX_CRC_W-1:0] bit_rev(input logic [MAX_CRC_W-1:0] v, input int w);
    logic [MAX_CRC_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_CRC_W; i++) begin
      if (i < w) r[w-1-i] = v[i];
    end
    return r;
  endfunction

  // Shifts data[data_w-1:0] through the CRC register MSB-first, one bit per iteration.
  function automatic logic [MAX_CRC_W-1:0] crc_step(input logic [MAX_CRC_W-1:0]  crc,
                                                    input logic [MAX_DATA_W-1:0] data,
                                                    input int                    crc_w,
                                                    input logic [MAX_CRC_W-1:0]  poly,
                                                    input int                    data_w);
    logic [MAX_CRC_W-1:0] c;
    logic [MAX_CRC_W-1:0] mask;
    logic                 fb;
    mask = (crc_w >= MAX_CRC_W) ? '1 : ((32'd1 << crc_w) - 32'd1);
    c    = crc & mask;
    for (int i = MAX_DATA_W - 1; i >= 0; i--) begin
      if (i < data_w) begin
        fb = data[i] ^ c[crc_w-1];
        c  = ((c << 1) ^ (fb ? poly : '0)) & mask;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_next.sv
// One-beat combinational CRC update: crc_out = step(crc_in, data).
// Reflected input is handled by reversing the beat so the shared step always runs MSB-first.
module crc_next
  import crc_pkg::*;
#(
  parameter int               CRC_W      = 8,
  parameter logic [CRC_W-1:0] POLY       = 8'h07,
  parameter int               DATA_W     = 8,
  parameter bit               REFLECT_IN = 1'b0
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out
);

  logic [DATA_W-1:0] data_ord;

  generate
    if (REFLECT_IN) begin : g_refl
      for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign data_ord[i] = data[DATA_W-1-i];
      end
    end else begin : g_norm
      assign data_ord = data;
    end
  endgenerate

  assign crc_out = CRC_W'(crc_step(32'(crc_in), 64'(data_ord), CRC_W, 32'(POLY), DATA_W));

endmodule

// File: rtl/crc_engine.sv
// Streaming CRC engine: one beat per cycle in, registered {crc, beat count} out at frame end.
// Result appears the cycle after s_last is accepted; input stalls while a result is pending.
module crc_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W       = 8,
  parameter logic [CRC_W-1:0] POLY        = 8'h07,
  parameter logic [CRC_W-1:0] INIT        = '0,
  parameter logic [CRC_W-1:0] XOR_OUT     = '0,
  parameter int               DATA_W      = 8,
  parameter bit               REFLECT_IN  = 1'b0,
  parameter bit               REFLECT_OUT = 1'b0,
  parameter int               LEN_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CRC_W-1:0]  m_crc,
  output logic [LEN_W-1:0]  m_len,
  output logic              busy
);

  state_e            state_q;
  logic [CRC_W-1:0]  crc_q;
  logic [CRC_W-1:0]  crc_d;
  logic [CRC_W-1:0]  res_d;
  logic [CRC_W-1:0]  m_crc_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_d;
  logic [LEN_W-1:0]  m_len_q;
  logic              m_valid_q;
  logic              busy_q;
  logic              beat_acc;

  crc_next #(
    .CRC_W     (CRC_W),
    .POLY      (POLY),
    .DATA_W    (DATA_W),
    .REFLECT_IN(REFLECT_IN)
  ) u_next (
    .crc_in (crc_q),
    .data   (s_data),
    .crc_out(crc_d)
  );

  assign s_ready  = (state_q == ST_RUN) && !clr;
  assign beat_acc = s_valid && s_ready;
  assign len_d    = (&len_q) ? len_q : len_q + 1'b1;
  assign res_d    = (REFLECT_OUT ? CRC_W'(bit_rev(32'(crc_d), CRC_W)) : crc_d) ^ XOR_OUT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      crc_q     <= INIT;
      len_q     <= '0;
      m_valid_q <= 1'b0;
      m_crc_q   <= '0;
      m_len_q   <= '0;
      busy_q    <= 1'b0;
    end else if (clr) begin
      // Abort drops both the partial frame and any result still waiting for m_ready.
      state_q   <= ST_RUN;
      crc_q     <= INIT;
      len_q     <= '0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (beat_acc) begin
            busy_q <= 1'b1;
            if (s_last) begin
              m_crc_q   <= res_d;
              m_len_q   <= len_d;
              m_valid_q <= 1'b1;
              crc_q     <= INIT;
              len_q     <= '0;
              state_q   <= ST_HOLD;
            end else begin
              crc_q <= crc_d;
              len_q <= len_d;
            end
          end
        end
        ST_HOLD: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign m_valid = m_valid_q;
  assign m_crc   = m_crc_q;
  assign m_len   = m_len_q;
  assign busy    = busy_q;

endmodule
